// File: rtl/mips_multicycle_controller.sv
// Main control FSM for the multicycle MIPS datapath: decodes op/funct and
// sequences ALU, memory, PC and register-file controls with a memory-ready stall.
module mips_multicycle_controller #(
    parameter int OP_W = 6,
    parameter int FN_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] op,
    input  logic [FN_W-1:0] funct,
    input  logic            zero,
    input  logic            mem_ready,
    output logic [2:0]      alucontrol,
    output logic            alusrca,
    output logic [1:0]      alusrcb,
    output logic [1:0]      pcsrc,
    output logic            pcen,
    output logic            iord,
    output logic            memwrite,
    output logic            mem_req,
    output logic            irwrite,
    output logic            regdst,
    output logic            memtoreg,
    output logic            regwrite,
    output logic            illegal_op,
    output logic [3:0]      state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    state_t cur, nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cur <= FETCH;
        else       cur <= nxt;
    end

    assign state = cur;

    always_comb begin
        nxt        = FETCH;
        alucontrol = 3'b010;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        pcen       = 1'b0;
        iord       = 1'b0;
        memwrite   = 1'b0;
        mem_req    = 1'b0;
        irwrite    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        illegal_op = 1'b0;
        case (cur)
            FETCH: begin
                mem_req = 1'b1;
                alusrcb = 2'b01;
                irwrite = mem_ready;
                pcen    = mem_ready;
                nxt     = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: nxt = MEMADR;
                    OP_RTYPE:     nxt = RTYPEEX;
                    OP_BEQ:       nxt = BEQEX;
                    OP_ADDI:      nxt = ADDIEX;
                    OP_J:         nxt = JEX;
                    default: begin
                        illegal_op = 1'b1;
                        nxt        = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                nxt     = (op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                nxt     = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            MEMWR: begin
                mem_req  = 1'b1;
                iord     = 1'b1;
                memwrite = 1'b1;
                nxt      = mem_ready ? FETCH : MEMWR;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                nxt     = RTYPEWB;
                case (funct)
                    6'b100000: alucontrol = 3'b010;
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    6'b100111: alucontrol = 3'b100;
                    default: begin
                        illegal_op = 1'b1;
                        nxt        = FETCH;
                    end
                endcase
            end
            RTYPEWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            BEQEX: begin
                alusrca    = 1'b1;
                alucontrol = 3'b110;
                pcsrc      = 2'b01;
                pcen       = zero;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                nxt     = ADDIWB;
            end
            ADDIWB: regwrite = 1'b1;
            JEX: begin
                pcsrc = 2'b10;
                pcen  = 1'b1;
            end
            default: nxt = FETCH;
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Directed per-cycle vector table for the multicycle controller, plus a
// hand-written reset-in-MEMRD sequence.
module tb_mips_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero, mem_ready;
    logic [2:0] alucontrol;
    logic       alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic       pcen, iord, memwrite, mem_req, irwrite;
    logic       regdst, memtoreg, regwrite, illegal_op;
    logic [3:0] state;

    int passed = 0;
    int total  = 0;

    mips_multicycle_controller #(.OP_W(6), .FN_W(6)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .alucontrol(alucontrol), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .pcen(pcen), .iord(iord),
        .memwrite(memwrite), .mem_req(mem_req), .irwrite(irwrite),
        .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
        .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        logic        rdy;
        logic [3:0]  st;
        logic [16:0] o;
    } vec_t;

    vec_t vecs[$];

    // {alucontrol, alusrca, alusrcb, pcsrc, pcen, iord, memwrite, mem_req,
    //  irwrite, regdst, memtoreg, regwrite, illegal_op}
    function automatic logic [16:0] mk(input logic [2:0] alu, input logic sa,
                                       input logic [1:0] sb, input logic [1:0] ps,
                                       input logic pe, io, mw, mr, irw, rd, m2r, rw, il);
        return {alu, sa, sb, ps, pe, io, mw, mr, irw, rd, m2r, rw, il};
    endfunction

    function automatic logic [16:0] outs();
        return {alucontrol, alusrca, alusrcb, pcsrc, pcen, iord, memwrite, mem_req,
                irwrite, regdst, memtoreg, regwrite, illegal_op};
    endfunction

    task automatic add(input logic [5:0] o_p, input logic [5:0] f, input logic z,
                       input logic r, input logic [3:0] st, input logic [16:0] o);
        vec_t v;
        v.op = o_p; v.funct = f; v.zero = z; v.rdy = r; v.st = st; v.o = o;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [16:0] got,
                       input logic [16:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s step=%0d got=%b exp=%b", name, idx, got, exp);
    endtask

    logic [16:0] F1, F0, DEC, DILL, MADR, MRD, MWB, MWR, RWB, AWB, JX;
    logic [5:0]  fns [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
    logic [2:0]  alus[6] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b100};

    initial begin
        F1   = mk(3'b010, 0, 2'b01, 2'b00, 1, 0, 0, 1, 1, 0, 0, 0, 0);
        F0   = mk(3'b010, 0, 2'b01, 2'b00, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        DEC  = mk(3'b010, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        DILL = mk(3'b010, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        MADR = mk(3'b010, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        MRD  = mk(3'b010, 0, 2'b00, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        MWB  = mk(3'b010, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        MWR  = mk(3'b010, 0, 2'b00, 2'b00, 0, 1, 1, 1, 0, 0, 0, 0, 0);
        RWB  = mk(3'b010, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        AWB  = mk(3'b010, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        JX   = mk(3'b010, 0, 2'b00, 2'b10, 1, 0, 0, 0, 0, 0, 0, 0, 0);

        // lw, no wait states: 5 cycles
        add(6'b100011, 0, 0, 1, 0, F1);
        add(6'b100011, 0, 0, 0, 1, DEC);
        add(6'b100011, 0, 0, 1, 2, MADR);
        add(6'b100011, 0, 0, 1, 3, MRD);
        add(6'b100011, 0, 0, 1, 4, MWB);
        // sw, one FETCH stall then three MEMWR waits
        add(6'b101011, 0, 0, 0, 0, F0);
        add(6'b101011, 0, 0, 1, 0, F1);
        add(6'b101011, 0, 0, 1, 1, DEC);
        add(6'b101011, 0, 0, 0, 2, MADR);
        add(6'b101011, 0, 0, 0, 5, MWR);
        add(6'b101011, 0, 0, 0, 5, MWR);
        add(6'b101011, 0, 0, 0, 5, MWR);
        add(6'b101011, 0, 0, 1, 5, MWR);
        // R-type funct sweep
        for (int unsigned i = 0; i < 6; i++) begin
            add(6'b000000, fns[i], 0, 1, 0, F1);
            add(6'b000000, fns[i], 0, 1, 1, DEC);
            add(6'b000000, fns[i], 0, 1, 6, mk(alus[i], 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            add(6'b000000, fns[i], 0, 1, 7, RWB);
        end
        // illegal funct: pulse, no writeback
        add(6'b000000, 6'b000001, 0, 1, 0, F1);
        add(6'b000000, 6'b000001, 0, 1, 1, DEC);
        add(6'b000000, 6'b000001, 0, 1, 6, mk(3'b010, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        // beq taken / not taken: 3 cycles each
        add(6'b000100, 0, 1, 1, 0, F1);
        add(6'b000100, 0, 1, 1, 1, DEC);
        add(6'b000100, 0, 1, 1, 8, mk(3'b110, 1, 2'b00, 2'b01, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        add(6'b000100, 0, 0, 1, 0, F1);
        add(6'b000100, 0, 0, 1, 1, DEC);
        add(6'b000100, 0, 0, 1, 8, mk(3'b110, 1, 2'b00, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // addi
        add(6'b001000, 0, 0, 1, 0, F1);
        add(6'b001000, 0, 0, 1, 1, DEC);
        add(6'b001000, 0, 0, 1, 9, MADR);
        add(6'b001000, 0, 0, 1, 10, AWB);
        // j
        add(6'b000010, 0, 0, 1, 0, F1);
        add(6'b000010, 0, 0, 1, 1, DEC);
        add(6'b000010, 0, 0, 1, 11, JX);
        // illegal op
        add(6'b111111, 0, 0, 1, 0, F1);
        add(6'b111111, 0, 0, 1, 1, DILL);
        add(6'b111111, 0, 0, 0, 0, F0);

        reset = 1'b1; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
        #1;
        chk("reset_state", -1, {13'd0, state}, 17'd0);
        chk("reset_outs", -1, outs(), F0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            op = vecs[i].op; funct = vecs[i].funct;
            zero = vecs[i].zero; mem_ready = vecs[i].rdy;
            #1;
            chk("state", i, {13'd0, state}, {13'd0, vecs[i].st});
            chk("outs", i, outs(), vecs[i].o);
        end

        // reset asserted while in MEMRD with mem_ready=1
        op = 6'b100011; funct = '0; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("pre_reset_memrd", 0, {13'd0, state}, 17'd3);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_state", 0, {13'd0, state}, 17'd0);
        chk("reset_no_regwrite", 0, {15'd0, regwrite, memwrite}, 17'd0);
        chk("reset_fetch_outs", 0, outs(), F1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_reset_fetch", 1, {13'd0, state}, 17'd0);
        chk("post_reset_outs", 1, outs(), F1);
        @(posedge clk);
        #1;
        chk("post_reset_decode", 2, {13'd0, state}, 17'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_controller.md
Name: mips_multicycle_controller

Overview:
- Main control FSM for the multicycle MIPS datapath; it generates the 3-bit alucontrol that drives the ALU, plus every datapath enable and mux select.
- Decodes op/funct from the instruction register and sequences each instruction over 3–5 cycles.
- Stalls on a memory-ready handshake.
- Sits between the instruction register/memory interface and the shared datapath (register file, ALU, PC).

Parameters:
- OP_W, 6, opcode width.
- FN_W, 6, funct width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; forces state to FETCH.
- op  in  6  instr[31:26] from the instruction register.
- funct  in  6  instr[5:0] from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access completes this cycle.
- alucontrol  out  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 100 NOR.
- alusrca  out  1  0 = PC, 1 = regA.
- alusrcb  out  2  00 = regB, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- pcsrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- pcen  out  1  PC load enable.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- memwrite  out  1  data memory write strobe.
- mem_req  out  1  memory access requested this cycle.
- irwrite  out  1  instruction register load.
- regdst  out  1  0 = rt, 1 = rd.
- memtoreg  out  1  0 = ALUOut, 1 = memory data.
- regwrite  out  1  register file write.
- illegal_op  out  1  one-cycle pulse on an unsupported op or funct.
- state  out  4  current state encoding, for debug.

Behaviour:
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11.
- Single state register; reset (async) sets FETCH. Unused encodings go to FETCH on the next edge.
- All outputs are combinational from state (Moore), except where mem_ready, zero, op or funct are noted.
- Any signal not listed for a state is 0. alucontrol defaults to 010.
- FETCH:
  - mem_req=1, iord=0, alusrca=0, alusrcb=01, alucontrol=010, pcsrc=00.
  - irwrite=pcen=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: alusrca=0, alusrcb=11, alucontrol=010. Next state by op:
  - 100011 (lw) or 101011 (sw) -> MEMADR.
  - 000000 (R-type) -> RTYPEEX.
  - 000100 (beq) -> BEQEX.
  - 001000 (addi) -> ADDIEX.
  - 000010 (j) -> JEX.
  - Any other op -> FETCH, with illegal_op=1 in this cycle.
- MEMADR: alusrca=1, alusrcb=10, alucontrol=010. op=100011 -> MEMRD, else MEMWR.
- MEMRD: mem_req=1, iord=1. Holds until mem_ready=1, then -> MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1. -> FETCH.
- MEMWR: mem_req=1, iord=1, memwrite=1. Holds until mem_ready=1, then -> FETCH. memwrite stays high for every wait cycle.
- RTYPEEX: alusrca=1, alusrcb=00. alucontrol decoded from funct:
  - 100000 -> 010; 100010 -> 110; 100100 -> 000; 100101 -> 001; 101010 -> 111; 100111 -> 100.
  - Legal funct -> RTYPEWB.
  - Any other funct -> alucontrol=010, illegal_op=1, -> FETCH with no writeback.
- RTYPEWB: regdst=1, memtoreg=0, regwrite=1. -> FETCH.
- BEQEX: alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01, pcen=zero. -> FETCH.
- ADDIEX: alusrca=1, alusrcb=10, alucontrol=010. -> ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1. -> FETCH.
- JEX: pcsrc=10, pcen=1. -> FETCH.
- Latency with zero wait states: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles. Each memory wait cycle adds 1.
- Reset mid-instruction: state is FETCH immediately and the in-flight instruction is abandoned. Outputs show FETCH values while reset is high. No regwrite/memwrite may be asserted while reset=1.
- mem_ready is ignored in states without mem_req.
- op and funct are sampled only in DECODE, MEMADR and RTYPEEX; the instruction register holds them stable after FETCH.
- pcen and regwrite are never both 1 outside FETCH/JEX/BEQEX combinations defined above.

Test Plan:
- Reset asserted in MEMRD, mem_ready=1 -> state=0 asynchronously, regwrite=0; next edge after release with mem_ready=1 -> irwrite=1, pcen=1, state=1.
- lw (op=100011), mem_ready=1 always -> states 0,1,2,3,4,0; MEMWB has regwrite=1, memtoreg=1, regdst=0; exactly 5 cycles.
- sw with mem_ready low 3 cycles in MEMWR -> memwrite=1 held for 4 cycles, iord=1; returns to FETCH; regwrite never 1.
- R-type funct sweep: 100000/100010/100100/100101/101010/100111 -> alucontrol 010/110/000/001/111/100 in RTYPEEX, then regdst=1, regwrite=1; funct=000001 -> illegal_op pulse, no regwrite, back to FETCH.
- beq with zero=1 -> pcen=1, pcsrc=01 in BEQEX; with zero=0 -> pcen=0; both take 3 cycles.
- j (op=000010) -> JEX pcen=1, pcsrc=10. op=111111 -> illegal_op=1 in DECODE, next state FETCH.
